// File: rtl/blinker_pkg.sv
// Shared display constants: digit/group counts, group indices and the lit mask.
// Latency: none (constants only).
// Backpressure: none.
package blinker_pkg;

    localparam int NUM_DIGITS       = 6;
    localparam int NUM_GROUPS       = 3;
    localparam int DIGITS_PER_GROUP = NUM_DIGITS / NUM_GROUPS;

    // Group indices within blink_control / blink_out
    localparam int GRP_SEC  = 0;
    localparam int GRP_MIN  = 1;
    localparam int GRP_HOUR = 2;

    typedef logic [NUM_DIGITS-1:0] digit_mask_t;

    localparam digit_mask_t ALL_LIT = '1;

endpackage

// File: rtl/blinker_phase.sv
// Free-running 1-bit blink phase: toggles on every blink strobe edge.
// Latency: new phase visible one edge after the previous one; resets to lit (1).
// Backpressure: none; the phase always advances.
module blink_phase (
    input  logic clk,
    input  logic rst_n,
    output logic phase
);

    // Phase flop: 1 = lit half-period, 0 = dark half-period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 1'b1;
        end else begin
            phase <= ~phase;
        end
    end

endmodule

// File: rtl/blinker.sv
// Per-digit blink mask for the 6-digit clock display; selected groups flash together.
// Latency: control sampled on a blink_pulse edge shows on blink_out at that same edge (registered).
// Backpressure: none; output is always valid, all ones while in reset.
module blinker
    import blinker_pkg::*;
#(
    parameter int GROUPS           = NUM_GROUPS,
    parameter int DIGITS_PER_GROUP = 2
) (
    input  logic                               blink_pulse,
    input  logic                               reset_n,
    input  logic [GROUPS-1:0]                  blink_control,
    output logic [GROUPS*DIGITS_PER_GROUP-1:0] blink_out
);

    localparam int W = GROUPS * DIGITS_PER_GROUP;

    logic         phase;
    logic         phase_next;
    logic [W-1:0] mask_next;

    blink_phase u_phase (
        .clk   (blink_pulse),
        .rst_n (reset_n),
        .phase (phase)
    );

    // The mask is built from the phase the flop is about to take, so the
    // registered output and the phase register always agree after an edge.
    assign phase_next = ~phase;

    // Selected groups follow the shared phase; unselected groups stay lit.
    // No realignment on selection: a newly selected group may go dark at once.
    for (genvar g = 0; g < GROUPS; g++) begin : g_group
        assign mask_next[g*DIGITS_PER_GROUP +: DIGITS_PER_GROUP] =
            blink_control[g] ? {DIGITS_PER_GROUP{phase_next}}
                             : {DIGITS_PER_GROUP{1'b1}};
    end

    // Registered output; reset forces every digit lit regardless of control
    always_ff @(posedge blink_pulse or negedge reset_n) begin
        if (!reset_n) begin
            blink_out <= '1;
        end else begin
            blink_out <= mask_next;
        end
    end

endmodule

// File: tb/tb_blinker.sv
// Self-checking bench for blinker: a reference phase model pushes expected masks
// to a scoreboard queue on each edge; each scenario task pops and compares.
// Outputs are sampled on the falling edge of blink_pulse.
module tb_blinker;

    logic       blink_pulse;
    logic       reset_n;
    logic [2:0] blink_control;
    logic [5:0] blink_out;

    int passed;
    int total;

    // Reference model state
    bit         m_phase;
    logic [5:0] sb[$];
    logic [5:0] exp_v;

    blinker dut (
        .blink_pulse   (blink_pulse),
        .reset_n       (reset_n),
        .blink_control (blink_control),
        .blink_out     (blink_out)
    );

    initial blink_pulse = 1'b0;
    always #5 blink_pulse = ~blink_pulse;

    // Called at a falling edge: apply control, take one rising edge, update the
    // model and push the expected mask, then return at the next falling edge.
    task automatic drive_edge(input logic [2:0] ctrl);
        logic [5:0] e;
        blink_control = ctrl;
        @(posedge blink_pulse);
        m_phase = ~m_phase;
        for (int g = 0; g < 3; g++) begin
            e[2*g +: 2] = ctrl[g] ? {2{m_phase}} : 2'b11;
        end
        sb.push_back(e);
        @(negedge blink_pulse);
    endtask

    // Synchronous-to-bench reset pulse, released at a falling edge
    task automatic do_reset();
        @(negedge blink_pulse);
        reset_n = 1'b0;
        @(negedge blink_pulse);
        reset_n = 1'b1;
        m_phase = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        blink_control = 3'b000;
        reset_n = 1'b0;
        @(negedge blink_pulse);
        @(negedge blink_pulse);
        total++;
        if (blink_out !== 6'b111111)
            $display("FAIL reset_value: got %b want %b", blink_out, 6'b111111);
        else passed++;
        reset_n = 1'b1;
        m_phase = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_edge(3'b000);
            exp_v = sb.pop_front();
            total++;
            if (blink_out !== exp_v)
                $display("FAIL idle_edge%0d: got %b want %b", i, blink_out, exp_v);
            else passed++;
        end
    endtask

    task automatic test_sec();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_edge(3'b001);
            exp_v = sb.pop_front();
            total++;
            if (blink_out !== exp_v)
                $display("FAIL sec_edge%0d: got %b want %b", i, blink_out, exp_v);
            else passed++;
        end
    endtask

    task automatic test_min_hour();
        for (int i = 0; i < 10; i++) begin
            drive_edge(i < 5 ? 3'b010 : 3'b100);
            exp_v = sb.pop_front();
            total++;
            if (blink_out !== exp_v)
                $display("FAIL min_hour_edge%0d: got %b want %b", i, blink_out, exp_v);
            else passed++;
        end
    endtask

    task automatic test_all_groups();
        for (int i = 0; i < 4; i++) begin
            drive_edge(3'b111);
            exp_v = sb.pop_front();
            total++;
            if (blink_out !== exp_v)
                $display("FAIL all_edge%0d: got %b want %b", i, blink_out, exp_v);
            else passed++;
        end
    endtask

    task automatic test_deselect();
        // Run hours blinking until the model says the group is dark
        for (int i = 0; i < 2; i++) begin
            drive_edge(3'b100);
            exp_v = sb.pop_front();
            total++;
            if (blink_out !== exp_v)
                $display("FAIL desel_pre%0d: got %b want %b", i, blink_out, exp_v);
            else passed++;
            if (m_phase == 1'b0) break;
        end
        drive_edge(3'b000);
        exp_v = sb.pop_front();
        total++;
        if (blink_out !== exp_v)
            $display("FAIL deselect_lit: got %b want %b", blink_out, exp_v);
        else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        drive_edge(3'b001);   // first edge after reset is dark for seconds
        exp_v = sb.pop_front();
        total++;
        if (blink_out !== exp_v)
            $display("FAIL arst_dark: got %b want %b", blink_out, exp_v);
        else passed++;
        // Assert reset between edges and check without any clock edge
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (blink_out !== 6'b111111)
            $display("FAIL arst_immediate: got %b want %b", blink_out, 6'b111111);
        else passed++;
        // Held across a rising edge while still in reset
        @(negedge blink_pulse);
        total++;
        if (blink_out !== 6'b111111)
            $display("FAIL arst_held: got %b want %b", blink_out, 6'b111111);
        else passed++;
        reset_n = 1'b1;
        m_phase = 1'b1;
        sb.delete();
        drive_edge(3'b001);
        exp_v = sb.pop_front();
        total++;
        if (blink_out !== 6'b111100)
            $display("FAIL arst_first_edge: got %b want %b", blink_out, 6'b111100);
        else passed++;
        total++;
        if (blink_out !== exp_v)
            $display("FAIL arst_first_edge_model: got %b want %b", blink_out, exp_v);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total = 0;
        reset_n = 1'b0;
        blink_control = 3'b000;
        m_phase = 1'b1;
        test_reset();
        test_sec();
        test_min_hour();
        test_all_groups();
        test_deselect();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule
